// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold/shift/load/rotate/clear with a
// direction-agnostic per-word shift counter that pulses word_done every WIDTH shifts.
module univ_shift_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           pi,
    input  logic                       sir,
    input  logic                       sil,
    output logic [WIDTH-1:0]           po,
    output logic                       sor,
    output logic                       sol,
    output logic [$clog2(WIDTH)-1:0]   cnt,
    output logic                       word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        SR   = 3'b001,
        SL   = 3'b010,
        LOAD = 3'b011,
        ROR  = 3'b100,
        ROL  = 3'b101,
        CLR  = 3'b110,
        RSVD = 3'b111
    } mode_t;

    mode_t op;
    logic  is_shift;

    assign op       = mode_t'(mode);
    assign is_shift = (op == SR) || (op == SL) || (op == ROR) || (op == ROL);
    assign sor      = po[0];
    assign sol      = po[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            po        <= RESET_VAL;
            cnt       <= '0;
            word_done <= 1'b0;
        end else if (!en) begin
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (op)
                SR:      po <= {sir, po[WIDTH-1:1]};
                SL:      po <= {po[WIDTH-2:0], sil};
                LOAD: begin
                    po  <= pi;
                    cnt <= '0;
                end
                ROR:     po <= {po[0], po[WIDTH-1:1]};
                ROL:     po <= {po[WIDTH-2:0], po[WIDTH-1]};
                CLR: begin
                    po  <= '0;
                    cnt <= '0;
                end
                default: po <= po;
            endcase
            // Counter wraps on the last shift of a word so consecutive words abut.
            if (is_shift) begin
                if (cnt == LAST) begin
                    cnt       <= '0;
                    word_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench: table-driven vectors on a 4-bit instance, plus a
// hand-written word sequence on an 8-bit instance with a non-zero reset value.
module tb_univ_shift_reg;

    localparam logic [2:0] M_HOLD = 3'b000, M_SR = 3'b001, M_SL = 3'b010, M_LOAD = 3'b011,
                           M_ROR = 3'b100, M_ROL = 3'b101, M_CLR = 3'b110, M_RSVD = 3'b111;

    logic       clk = 1'b0;
    logic       reset4, en4, sir4, sil4;
    logic [2:0] mode4;
    logic [3:0] pi4, po4;
    logic       sor4, sol4, wd4;
    logic [1:0] cnt4;

    logic       reset8, en8, sir8, sil8;
    logic [2:0] mode8;
    logic [7:0] pi8, po8;
    logic       sor8, sol8, wd8;
    logic [2:0] cnt8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .mode(mode4), .pi(pi4),
        .sir(sir4), .sil(sil4), .po(po4), .sor(sor4), .sol(sol4),
        .cnt(cnt4), .word_done(wd4)
    );

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .pi(pi8),
        .sir(sir8), .sil(sil8), .po(po8), .sor(sor8), .sol(sol8),
        .cnt(cnt8), .word_done(wd8)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] mode;
        logic [3:0] pi;
        logic       sir;
        logic       sil;
        logic [3:0] exp_po;
        logic [1:0] exp_cnt;
        logic       exp_wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                                input logic [3:0] p, input logic si_r, input logic si_l,
                                input logic [3:0] ep, input logic [1:0] ec, input logic ew);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.pi = p; v.sir = si_r; v.sil = si_l;
        v.exp_po = ep; v.exp_cnt = ec; v.exp_wd = ew;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset4 = v.rst_n; en4 = v.en; mode4 = v.mode; pi4 = v.pi; sir4 = v.sir; sil4 = v.sil;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] p, input logic si_r);
        @(negedge clk);
        reset8 = r; en8 = e; mode8 = m; pi8 = p; sir8 = si_r; sil8 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp8 [8];
        reset4 = 1'b0; en4 = 1'b1; mode4 = M_LOAD; pi4 = 4'hF; sir4 = 1'b0; sil4 = 1'b0;
        reset8 = 1'b0; en8 = 1'b1; mode8 = M_LOAD; pi8 = 8'hFF; sir8 = 1'b0; sil8 = 1'b0;

        // reset with LOAD of F requested: pi ignored
        vecs.push_back(mk(0, 1, M_LOAD, 4'hF, 0, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, M_LOAD, 4'hF, 0, 0, 4'b0000, 0, 0));
        // PISO/SISO right
        vecs.push_back(mk(1, 1, M_LOAD, 4'b1010, 0, 0, 4'b1010, 0, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1101, 1, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1110, 2, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1111, 3, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1111, 0, 1));
        // SIPO left
        vecs.push_back(mk(1, 1, M_CLR,  4'hF,    0, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 1, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 0, 4'b0010, 2, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 1, 4'b0101, 3, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 1, 4'b1011, 0, 1));
        // rotate
        vecs.push_back(mk(1, 1, M_LOAD, 4'b1001, 0, 0, 4'b1001, 0, 0));
        vecs.push_back(mk(1, 1, M_ROL,  4'h0,    0, 0, 4'b0011, 1, 0));
        vecs.push_back(mk(1, 1, M_ROL,  4'h0,    0, 0, 4'b0110, 2, 0));
        vecs.push_back(mk(1, 1, M_ROL,  4'h0,    0, 0, 4'b1100, 3, 0));
        vecs.push_back(mk(1, 1, M_ROL,  4'h0,    0, 0, 4'b1001, 0, 1));
        vecs.push_back(mk(1, 1, M_ROR,  4'h0,    0, 0, 4'b1100, 1, 0));
        // hold via en=0, then LOAD aborts the partial word
        vecs.push_back(mk(1, 1, M_LOAD, 4'b0110, 1, 1, 4'b0110, 0, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 1, 4'b0011, 1, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 1, 4'b0001, 2, 0));
        vecs.push_back(mk(1, 0, M_SR,   4'h0,    1, 1, 4'b0001, 2, 0));
        vecs.push_back(mk(1, 0, M_SR,   4'h0,    1, 1, 4'b0001, 2, 0));
        vecs.push_back(mk(1, 0, M_SR,   4'h0,    1, 1, 4'b0001, 2, 0));
        vecs.push_back(mk(1, 1, M_LOAD, 4'b1111, 0, 0, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0111, 1, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0011, 2, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0001, 3, 0));
        // reserved and HOLD keep state and count
        vecs.push_back(mk(1, 1, M_RSVD, 4'hF,    1, 1, 4'b0001, 3, 0));
        vecs.push_back(mk(1, 1, M_HOLD, 4'hF,    1, 1, 4'b0001, 3, 0));
        // back-to-back words, direction change keeps counting
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1000, 0, 1));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 0, 4'b0000, 2, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 0, 4'b0000, 3, 0));
        vecs.push_back(mk(1, 1, M_SL,   4'h0,    0, 0, 4'b0000, 0, 1));
        // reset mid-word abandons the partial count
        vecs.push_back(mk(1, 1, M_LOAD, 4'b1010, 0, 0, 4'b1010, 0, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1101, 1, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1110, 2, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1111, 3, 0));
        vecs.push_back(mk(0, 1, M_SR,   4'h0,    1, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0000, 2, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0000, 3, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    0, 0, 4'b0000, 0, 1));
        // CLR mid-word resets the count without a pulse
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1000, 1, 0));
        vecs.push_back(mk(1, 1, M_CLR,  4'h0,    1, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 1, M_SR,   4'h0,    1, 0, 4'b1000, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("w4[%0d].po", i),  32'(po4),  32'(vecs[i].exp_po));
            checkOutput($sformatf("w4[%0d].cnt", i), 32'(cnt4), 32'(vecs[i].exp_cnt));
            checkOutput($sformatf("w4[%0d].word_done", i), 32'(wd4), 32'(vecs[i].exp_wd));
            checkOutput($sformatf("w4[%0d].sor", i), 32'(sor4), 32'(vecs[i].exp_po[0]));
            checkOutput($sformatf("w4[%0d].sol", i), 32'(sol4), 32'(vecs[i].exp_po[3]));
        end

        // 8-bit instance: reset value A5, then a full 8-shift word
        step8(0, 1, M_LOAD, 8'hFF, 0);
        step8(0, 1, M_LOAD, 8'hFF, 0);
        checkOutput("w8.reset_po", 32'(po8), 32'h A5);
        checkOutput("w8.reset_cnt", 32'(cnt8), 32'd0);
        checkOutput("w8.reset_wd", 32'(wd8), 32'd0);
        step8(1, 1, M_LOAD, 8'hAA, 0);
        checkOutput("w8.load_po", 32'(po8), 32'h AA);
        checkOutput("w8.load_sor", 32'(sor8), 32'd0);
        checkOutput("w8.load_sol", 32'(sol8), 32'd1);
        exp8 = '{8'hD5, 8'hEA, 8'hF5, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            step8(1, 1, M_SR, 8'h00, 1);
            checkOutput($sformatf("w8.sr%0d.po", i), 32'(po8), 32'(exp8[i]));
            checkOutput($sformatf("w8.sr%0d.cnt", i), 32'(cnt8), 32'((i + 1) % 8));
            checkOutput($sformatf("w8.sr%0d.word_done", i), 32'(wd8), (i == 7) ? 32'd1 : 32'd0);
        end
        step8(1, 1, M_HOLD, 8'h00, 0);
        checkOutput("w8.pulse_drop", 32'(wd8), 32'd0);
        checkOutput("w8.hold_po", 32'(po8), 32'h FF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
